chaos_keystream_ctrl: RTL and testbench
=======================================

# chaos_keystream_ctrl

Sequencer for the 16-bit fixed-point logistic-map generator, x ← 4·x·(1−x) in Q1.15. The block owns the map state register and accepts a seed over a ready/valid port. It runs a programmable warm-up that discards the first iterations, then packs the map's MSB output bits into words and delivers them over a valid/ready keystream port with backpressure. It sits between the chaotic core arithmetic and downstream consumers such as the LFSR combiner and the test sink.

## Interface
- WARMUP_CYCLES, 64: map iterations discarded after start; 0 means go straight to RUN.
- WORD_W, 8: keystream word width in bits, ≥2.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- seed  input  16  initial map value.
- seed_valid  input  1  seed offered.
- seed_ready  output  1  high only in IDLE.
- start  input  1  begin warm-up; sampled in IDLE only.
- stop  input  1  abort to IDLE; sampled in WARMUP and RUN.
- ks_data  output  WORD_W  packed keystream word; first bit is the MSB.
- ks_valid  output  1  ks_data holds an unconsumed word.
- ks_ready  input  1  consumer accepts the word.
- busy  output  1  state is WARMUP or RUN.
- stuck_cnt  output  8  saturating count of fixed-point recoveries.

## Operation
- Map step, all unsigned:
  - d = (16'h7FFF − x) mod 2^16.
  - p = x·d, 32 bits.
  - m = (p << 2) truncated to 32 bits.
  - x_next = m[30:15].
  - Output bit b = x_next[15].
  - x updates only on cycles that are stepping cycles.
- States are IDLE, WARMUP and RUN.
- IDLE:
  - x holds.
  - If seed_valid is high, x ← seed.
  - If start is high, go to WARMUP with warm_cnt ← WARMUP_CYCLES. If WARMUP_CYCLES = 0, go directly to RUN.
  - If seed and start arrive in the same cycle, both take effect, so warm-up iterates from the new seed.
- WARMUP:
  - Every cycle is a stepping cycle, and b is discarded.
  - warm_cnt decrements each cycle.
  - On the step where warm_cnt goes 1→0, move to RUN with the pack register empty.
- RUN:
  - Each stepping cycle shifts b into the pack register at the LSB and increments bit_cnt.
  - Cycles with bit_cnt < WORD_W−1 always step.
  - The cycle with bit_cnt = WORD_W−1 steps only if the output slot is free, i.e. !ks_valid || ks_ready. On that step:
    - ks_data ← {pack[WORD_W−2:0], b}.
    - ks_valid ← 1.
    - bit_cnt ← 0.
  - If the slot is not free, x, pack and bit_cnt all hold.
- Output handshake:
  - A word transfers on ks_valid && ks_ready.
  - ks_valid falls after the transfer unless a new word loads on the same edge.
  - ks_data is stable while ks_valid && !ks_ready.
- stop, in WARMUP or RUN:
  - Next state is IDLE; the partial pack and bit_cnt are cleared.
  - x retains its value.
  - A pending ks_data/ks_valid word is kept until it is consumed.
  - stop has priority over a word completion in the same cycle: no new word is loaded.
- start outside IDLE is ignored. stop in IDLE is ignored.

## Timing
- Reset values:
  - x = 16'h4000 and state = IDLE.
  - ks_data = 0, ks_valid = 0.
  - seed_ready = 1, busy = 0.
  - stuck_cnt = 0; warm_cnt, bit_cnt and pack = 0.
- Reset asserted mid-operation returns to these values immediately (asynchronous); any unconsumed word is lost.
- Start latency: with start sampled at edge 0 and ks_ready held high:
  - Warm-up steps occur on edges 1..WARMUP_CYCLES.
  - The first word sets ks_valid at edge WARMUP_CYCLES+WORD_W.
  - Throughput is then one word per WORD_W cycles.
- busy rises the cycle after start is sampled and falls the cycle after stop is sampled.
- seed_ready is combinational from state.

## Configuration
- CHAOS_STUCK_RESEED_EN:
  - Defined: on any stepping cycle with x_next == x (fixed point, including 0), x ← x ^ 16'h2A55 instead of x_next. b is still taken from x_next, and stuck_cnt increments, saturating at 255.
  - Undefined: fixed points persist, and stuck_cnt is tied to 0.

## Test plan
- Reset with rst low → x = 0x4000, ks_valid = 0, seed_ready = 1, busy = 0, stuck_cnt = 0.
- WARMUP_CYCLES = 0, WORD_W = 8, seed 0x4000, start, ks_ready high → map sequence is 0x7FFE, 0x0003, 0x000B; the first three bits are 0,0,0; the first ks_valid appears at edge 8.
- Backpressure: ks_ready held low after the first word → ks_data stable, x frozen after 7 further steps; ks_ready high for 1 cycle → that word transfers and the next word loads on the same edge.
- stop mid-RUN with 3 bits packed → IDLE next cycle, busy = 0, partial bits discarded, pending word retained until ks_ready.
- Seed 0x0000 with the macro undefined → every word is 0x00, stuck_cnt = 0. With CHAOS_STUCK_RESEED_EN defined → the first step yields x = 0x2A55 and stuck_cnt = 1.
- seed_valid + start in the same IDLE cycle with WARMUP_CYCLES = 64 → warm-up starts from the new seed; the first word appears at edge 72.

Source files
------------

// File: rtl/chaos_keystream_ctrl.sv
// chaos_keystream_ctrl: logistic-map keystream sequencer (Q1.15).
// Optional fixed-point recovery: define CHAOS_STUCK_RESEED_EN.
module chaos_keystream_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int WORD_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       seed,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              start,
  input  logic              stop,
  output logic [WORD_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              busy,
  output logic [7:0]        stuck_cnt
);
  localparam int WCW =
    (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam int BCW = $clog2(WORD_W);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP_CYCLES);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e              state_q;
  logic [15:0]         x_q;
  logic [WCW-1:0]      warm_cnt_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [WORD_W-2:0]   pack_q;
  logic [WORD_W-1:0]   ks_data_q;
  logic                ks_valid_q;
  logic                busy_q;

  logic [15:0]         diff_w;
  logic [31:0]         prod_w;
  logic [31:0]         m_w;
  logic [15:0]         xn_w;
  logic [15:0]         x_d;
  logic                bit_w;
  logic [WORD_W-1:0]   word_w;
  logic                last_w;
  logic                slot_w;
  logic                step_w;
  logic                unused_m;

  assign diff_w   = 16'h7FFF - x_q;
  assign prod_w   = {16'h0, x_q} * {16'h0, diff_w};
  assign m_w      = {prod_w[29:0], 2'b00};
  assign xn_w     = m_w[30:15];
  assign bit_w    = xn_w[15];
  assign unused_m = ^{prod_w[31:30], m_w[31], m_w[14:0]};
  assign word_w   = {pack_q, bit_w};

`ifdef CHAOS_STUCK_RESEED_EN
  logic       fixed_w;
  logic [7:0] stuck_q;

  assign fixed_w = (xn_w == x_q);
  assign x_d     = fixed_w ? (x_q ^ 16'h2A55) : xn_w;

  // Count fixed-point recoveries, saturating at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuck_q <= 8'd0;
    end else if (step_w && fixed_w && stuck_q != 8'hFF) begin
      stuck_q <= stuck_q + 8'd1;
    end
  end

  assign stuck_cnt = stuck_q;
`else
  assign x_d       = xn_w;
  assign stuck_cnt = 8'd0;
`endif

  assign last_w = (bit_cnt_q == BIT_LAST);
  assign slot_w = !ks_valid_q || ks_ready;

  // A cycle steps the map unless stopping or stalled on a full slot
  always_comb begin
    step_w = 1'b0;
    unique case (state_q)
      WARMUP:  step_w = !stop;
      RUN:     step_w = !stop && (!last_w || slot_w);
      default: step_w = 1'b0;
    endcase
  end

  // Sequencer, map state, bit packing and output slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      x_q        <= 16'h4000;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      pack_q     <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (ks_valid_q && ks_ready) ks_valid_q <= 1'b0;
      if (step_w) x_q <= x_d;
      unique case (state_q)
        IDLE: begin
          if (seed_valid) x_q <= seed;
          if (start) begin
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            pack_q    <= '0;
            if (WARMUP_CYCLES == 0) begin
              state_q <= RUN;
            end else begin
              state_q    <= WARMUP;
              warm_cnt_q <= WARM_INIT;
            end
          end
        end
        WARMUP: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            warm_cnt_q <= warm_cnt_q - WCW'(1);
            if (warm_cnt_q == WCW'(1)) begin
              state_q   <= RUN;
              bit_cnt_q <= '0;
              pack_q    <= '0;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            pack_q    <= '0;
          end else if (step_w) begin
            pack_q <= word_w[WORD_W-2:0];
            if (last_w) begin
              ks_data_q  <= word_w;
              ks_valid_q <= 1'b1;
              bit_cnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign seed_ready = (state_q == IDLE);
  assign ks_data    = ks_data_q;
  assign ks_valid   = ks_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_chaos_keystream_ctrl.sv
// tb_chaos_keystream_ctrl: scoreboard bench for the keystream sequencer.
// Expected words come from a behavioural map model.
module tb_chaos_keystream_ctrl;
  localparam int W = 8;
`ifdef CHAOS_STUCK_RESEED_EN
  localparam int STUCK_EXP = 1;
`else
  localparam int STUCK_EXP = 0;
`endif

  logic         clk;
  logic         rst;
  logic [15:0]  seed;
  logic         seed_valid;
  logic         seed_ready;
  logic         start;
  logic         stop;
  logic [W-1:0] ks_data;
  logic         ks_valid;
  logic         ks_ready;
  logic         busy;
  logic [7:0]   stuck_cnt;

  logic         seed_ready_b;
  logic         start_b;
  logic [W-1:0] ks_data_b;
  logic         ks_valid_b;
  logic         ks_ready_b;
  logic         busy_b;
  logic [7:0]   stuck_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] w1, w2, wb;
  logic [15:0]  xm;
  int k;

  chaos_keystream_ctrl #(.WARMUP_CYCLES(0), .WORD_W(W)) dut (
    .clk(clk), .rst(rst),
    .seed(seed), .seed_valid(seed_valid),
    .seed_ready(seed_ready),
    .start(start), .stop(stop),
    .ks_data(ks_data), .ks_valid(ks_valid),
    .ks_ready(ks_ready),
    .busy(busy), .stuck_cnt(stuck_cnt)
  );

  chaos_keystream_ctrl #(.WARMUP_CYCLES(64), .WORD_W(W)) dut_b (
    .clk(clk), .rst(rst),
    .seed(seed), .seed_valid(seed_valid),
    .seed_ready(seed_ready_b),
    .start(start_b), .stop(stop),
    .ks_data(ks_data_b), .ks_valid(ks_valid_b),
    .ks_ready(ks_ready_b),
    .busy(busy_b), .stuck_cnt(stuck_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mstep(input logic [15:0] x);
    logic [15:0] d;
    logic [15:0] n;
    logic [31:0] p;
    d = 16'h7FFF - x;
    p = {16'h0, x} * {16'h0, d};
    p = p << 2;
    n = p[30:15];
`ifdef CHAOS_STUCK_RESEED_EN
    if (n == x) return {n[15], x ^ 16'h2A55};
`endif
    return {n[15], n};
  endfunction

  task automatic run_steps(input logic [15:0] xi, input int n,
                           output logic [15:0] xo);
    logic [16:0] r;
    logic [15:0] x;
    x = xi;
    for (int i = 0; i < n; i++) begin
      r = mstep(x);
      x = r[15:0];
    end
    xo = x;
  endtask

  task automatic next_word(input logic [15:0] xi,
                           output logic [W-1:0] w,
                           output logic [15:0] xo);
    logic [16:0] r;
    logic [15:0] x;
    x = xi;
    w = '0;
    for (int i = 0; i < W; i++) begin
      r = mstep(x);
      x = r[15:0];
      w = {w[W-2:0], r[16]};
    end
    xo = x;
  endtask

  task automatic gen(input logic [15:0] xi, input int nw,
                     output logic [15:0] xo);
    logic [W-1:0] w;
    logic [15:0]  x;
    x = xi;
    for (int j = 0; j < nw; j++) begin
      next_word(x, w, x);
      exp_q.push_back(w);
    end
    xo = x;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && ks_valid && ks_ready) begin
      check("ks_pend", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("ks_word", 32'(ks_data), 32'(exp_w));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    seed = '0; seed_valid = 1'b0;
    start = 1'b0; start_b = 1'b0; stop = 1'b0;
    ks_ready = 1'b1; ks_ready_b = 1'b1;
    #1 rst = 1'b0;
    #11;
    check("rst_valid", 32'(ks_valid), 32'd0);
    check("rst_data", 32'(ks_data), 32'd0);
    check("rst_sready", 32'(seed_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stuck", 32'(stuck_cnt), 32'd0);
    #10 rst = 1'b1;
    tick;

    // Run from the reset value, then backpressure
    gen(16'h4000, 2, xm);
    w1 = exp_q[0];
    w2 = exp_q[1];
    start = 1'b1; tick; start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    k = 0;
    while (!ks_valid && k < 20) begin
      tick;
      k++;
    end
    ks_ready = 1'b0;
    check("first_edge", 32'(k), 32'd8);
    check("first_bits", 32'(ks_data[7:5]), 32'd0);
    repeat (12) tick;
    check("bp_data", 32'(ks_data), 32'(w1));
    check("bp_valid", 32'(ks_valid), 32'd1);
    ks_ready = 1'b1; tick; ks_ready = 1'b0;
    check("reload_v", 32'(ks_valid), 32'd1);
    check("reload_d", 32'(ks_data), 32'(w2));

    // Stop with three bits packed and a word pending
    repeat (3) tick;
    stop = 1'b1; tick; stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sready", 32'(seed_ready), 32'd1);
    check("stop_valid", 32'(ks_valid), 32'd1);
    check("stop_data", 32'(ks_data), 32'(w2));
    repeat (2) tick;
    check("hold_valid", 32'(ks_valid), 32'd1);
    ks_ready = 1'b1; tick;
    check("drain_valid", 32'(ks_valid), 32'd0);

    // Restart from the retained x with an empty pack
    run_steps(xm, 3, xm);
    gen(xm, 2, xm);
    start = 1'b1; tick; start = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick;
      k++;
    end
    check("restart_drain", 32'(exp_q.size()), 32'd0);
    stop = 1'b1; tick; stop = 1'b0; tick;

    // Asynchronous reset with a word pending
    ks_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    repeat (10) tick;
    check("pre_rst_v", 32'(ks_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(ks_valid), 32'd0);
    check("arst_data", 32'(ks_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sready", 32'(seed_ready), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    tick;
    exp_q.delete();
    ks_ready = 1'b1;

    // Zero seed: fixed point
    seed = 16'h0000; seed_valid = 1'b1; tick; seed_valid = 1'b0;
    gen(16'h0000, 2, xm);
    start = 1'b1; tick; start = 1'b0;
    tick;
    check("stuck_first", 32'(stuck_cnt), 32'(STUCK_EXP));
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick;
      k++;
    end
    check("seed0_drain", 32'(exp_q.size()), 32'd0);
    stop = 1'b1; tick; stop = 1'b0; tick;

    // Seed and start together, 64-step warm-up
    seed = 16'h1234; seed_valid = 1'b1; start_b = 1'b1;
    tick;
    seed_valid = 1'b0; start_b = 1'b0;
    run_steps(16'h1234, 64, xm);
    next_word(xm, wb, xm);
    k = 0;
    while (!ks_valid_b && k < 100) begin
      tick;
      k++;
    end
    check("b_latency", 32'(k), 32'd72);
    check("b_word", 32'(ks_data_b), 32'(wb));
    stop = 1'b1; tick; stop = 1'b0; tick;
    check("b_idle", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
